// File: rtl/bmp_pkg.sv
// Shared constants for the BMP unpacker: FSM encodings, BMP header field offsets,
// header check values and the RGB888 -> RGB565 packer.
package bmp_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HDR  = 3'd1;
   localparam logic [2:0] ST_PIX  = 3'd2;
   localparam logic [2:0] ST_PAD  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;
   localparam logic [2:0] ST_ERR  = 3'd5;

   // Little-endian field byte offsets inside the 54-byte BMP header
   localparam int OFS_MAGIC0 = 0;
   localparam int OFS_MAGIC1 = 1;
   localparam int OFS_DOFF0  = 10;
   localparam int OFS_DOFF3  = 13;
   localparam int OFS_WIDTH0 = 18;
   localparam int OFS_WIDTH3 = 21;
   localparam int OFS_HGT0   = 22;
   localparam int OFS_HGT1   = 23;
   localparam int OFS_BPP0   = 28;
   localparam int OFS_BPP1   = 29;

   localparam logic [7:0]  MAGIC_B  = 8'h42;
   localparam logic [7:0]  MAGIC_M  = 8'h4D;
   localparam logic [15:0] BPP_24   = 16'd24;
   localparam logic [31:0] MIN_DOFF = 32'd54;

   function automatic logic [15:0] rgb888_to_565(input logic [7:0] r, input logic [7:0] g,
                                                 input logic [7:0] b);
      return {r[7:3], g[7:2], b[7:3]};
   endfunction

endpackage

// File: rtl/bmp_header_parser.sv
// Counts header bytes, captures the BMP fields the unpacker depends on and flags the
// first offending byte; only used when BMP_HEADER_PARSE_EN is defined.
module bmp_header_parser
   import bmp_pkg::*;
#(
   parameter int IMG_W = 480,
   parameter int IMG_H = 272
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       hdr_last,
   output logic       hdr_err
);

   logic [31:0] byte_cnt;
   logic [31:0] doff;
   logic [23:0] width_lo;
   logic [7:0]  height_lo;
   logic [7:0]  bpp_lo;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         byte_cnt  <= '0;
         doff      <= '0;
         width_lo  <= '0;
         height_lo <= '0;
         bpp_lo    <= '0;
      end else if (byte_valid) begin
         byte_cnt <= byte_cnt + 32'd1;
         case (byte_cnt)
            32'(OFS_DOFF0):      doff[7:0]       <= byte_data;
            32'(OFS_DOFF0 + 1):  doff[15:8]      <= byte_data;
            32'(OFS_DOFF0 + 2):  doff[23:16]     <= byte_data;
            32'(OFS_DOFF3):      doff[31:24]     <= byte_data;
            32'(OFS_WIDTH0):     width_lo[7:0]   <= byte_data;
            32'(OFS_WIDTH0 + 1): width_lo[15:8]  <= byte_data;
            32'(OFS_WIDTH0 + 2): width_lo[23:16] <= byte_data;
            32'(OFS_HGT0):       height_lo       <= byte_data;
            32'(OFS_BPP0):       bpp_lo          <= byte_data;
            default: ;
         endcase
      end
   end

   // Each field is judged on its last byte, using the incoming byte as the MSB
   always_comb begin
      hdr_err = 1'b0;
      if (byte_valid) begin
         case (byte_cnt)
            32'(OFS_MAGIC0): hdr_err = (byte_data != MAGIC_B);
            32'(OFS_MAGIC1): hdr_err = (byte_data != MAGIC_M);
            32'(OFS_DOFF3):  hdr_err = ({byte_data, doff[23:0]} < MIN_DOFF);
            32'(OFS_WIDTH3): hdr_err = ({byte_data, width_lo} != 32'(IMG_W));
            32'(OFS_HGT1):   hdr_err = ({byte_data, height_lo} != 16'(IMG_H));
            32'(OFS_BPP1):   hdr_err = ({byte_data, bpp_lo} != BPP_24);
            default:         hdr_err = 1'b0;
         endcase
      end
   end

   // doff is only trustworthy once all checks are behind us (doff >= 54 > 29)
   assign hdr_last = byte_valid && (byte_cnt > 32'(OFS_BPP1)) && (byte_cnt + 32'd1 == doff);

endmodule

// File: rtl/bmp_stream_unpacker.sv
// 24-bit BMP byte stream to RGB565 pixel writes: header skip/parse, BGR capture,
// row padding removal and frame framing. Optional header checks: BMP_HEADER_PARSE_EN.
module bmp_stream_unpacker
   import bmp_pkg::*;
#(
   parameter int IMG_W     = 480,
   parameter int IMG_H     = 272,
   parameter int HDR_BYTES = 54
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        write_req,
   output logic        write_en,
   output logic [15:0] write_data,
   output logic        frame_done,
   output logic        error,
   output logic [1:0]  state_code
);

   localparam int PAD_N = (4 - (IMG_W * 3) % 4) % 4;
   localparam int CW    = $clog2(IMG_W + 1);
   localparam int RW    = $clog2(IMG_H + 1);

   logic [2:0]    state;
   logic [1:0]    phase;
   logic [1:0]    pad_cnt;
   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
   logic [7:0]    b_q;
   logic [7:0]    g_q;
   logic          start_ok;
   logic          hdr_vld;
   logic          hdr_last;
   logic          hdr_err;

   assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
   assign hdr_vld  = byte_valid && (state == ST_HDR);

`ifdef BMP_HEADER_PARSE_EN
   bmp_header_parser #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_hdr (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_ok),
      .byte_valid (hdr_vld),
      .byte_data  (byte_data),
      .hdr_last   (hdr_last),
      .hdr_err    (hdr_err)
   );

   always_ff @(posedge clk) begin
      if (rst || start_ok) error <= 1'b0;
      else if (hdr_err)    error <= 1'b1;
   end
`else
   logic [31:0] byte_cnt;

   always_ff @(posedge clk) begin
      if (rst || start_ok) byte_cnt <= '0;
      else if (hdr_vld)    byte_cnt <= byte_cnt + 32'd1;
   end

   assign hdr_last = hdr_vld && (byte_cnt == 32'(HDR_BYTES - 1));
   assign hdr_err  = 1'b0;
   assign error    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         phase      <= '0;
         pad_cnt    <= '0;
         col_cnt    <= '0;
         row_cnt    <= '0;
         b_q        <= '0;
         g_q        <= '0;
         write_en   <= 1'b0;
         write_data <= '0;
         frame_done <= 1'b0;
      end else begin
         write_en   <= 1'b0;
         frame_done <= 1'b0;
         if (start_ok) begin
            state   <= ST_HDR;
            phase   <= '0;
            pad_cnt <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
         end else begin
            case (state)
               ST_HDR: begin
                  if (hdr_err)       state <= ST_ERR;
                  else if (hdr_last) state <= ST_PIX;
               end
               ST_PIX: begin
                  if (byte_valid) begin
                     case (phase)
                        2'd0: begin b_q <= byte_data; phase <= 2'd1; end
                        2'd1: begin g_q <= byte_data; phase <= 2'd2; end
                        default: begin
                           phase      <= 2'd0;
                           write_en   <= 1'b1;
                           write_data <= rgb888_to_565(byte_data, g_q, b_q);
                           if (col_cnt == CW'(IMG_W - 1)) begin
                              col_cnt <= '0;
                              row_cnt <= row_cnt + 1'b1;
                              // Last row's trailing padding is simply dropped in DONE
                              if (row_cnt == RW'(IMG_H - 1)) begin
                                 state      <= ST_DONE;
                                 frame_done <= 1'b1;
                              end else if (PAD_N > 0) begin
                                 state <= ST_PAD;
                              end
                           end else begin
                              col_cnt <= col_cnt + 1'b1;
                           end
                        end
                     endcase
                  end
               end
               ST_PAD: begin
                  if (byte_valid) begin
                     if (pad_cnt == 2'(PAD_N - 1)) begin
                        pad_cnt <= '0;
                        state   <= ST_PIX;
                     end else begin
                        pad_cnt <= pad_cnt + 2'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign write_req = (state == ST_HDR);

   always_comb begin
      state_code = 2'd3;
      case (state)
         ST_IDLE:        state_code = 2'd0;
         ST_HDR:         state_code = 2'd1;
         ST_PIX, ST_PAD: state_code = 2'd2;
         default:        state_code = 2'd3;
      endcase
   end

endmodule

// File: tb/tb_bmp_stream_unpacker.sv
// Directed bench for bmp_stream_unpacker with a 5x2 image (one pad byte per row).
module tb_bmp_stream_unpacker;

   localparam int W = 5;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        write_req, write_en, frame_done, error;
   logic [15:0] write_data;
   logic [1:0]  state_code;

   int checks = 0;
   int errors = 0;

   logic [15:0] got_q[$];
   int fd_cnt = 0;
   int fd_with_we = 0;
   int wreq_cnt = 0;

   always #5 clk = ~clk;

   bmp_stream_unpacker #(.IMG_W(W), .IMG_H(H), .HDR_BYTES(54)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .write_req  (write_req),
      .write_en   (write_en),
      .write_data (write_data),
      .frame_done (frame_done),
      .error      (error),
      .state_code (state_code)
   );

   always @(negedge clk) begin
      if (write_en) begin
         got_q.push_back(write_data);
         if (frame_done) fd_with_we++;
      end
      if (frame_done) fd_cnt++;
      if (write_req) wreq_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] hdr_byte(input int i, input int bpp);
      case (i)
         0:       return 8'h42;
         1:       return 8'h4D;
         10:      return 8'd54;
         18:      return 8'(W);
         22:      return 8'(H);
         26:      return 8'd1;
         28:      return 8'(bpp);
         default: return 8'h00;
      endcase
   endfunction

   // Pixel k is B=8k, G=4k, R=8(k+1) -> {k+1, k, k} in the 5/6/5 fields
   function automatic logic [15:0] exp_px(input int k);
      return 16'(((k + 1) << 11) | (k << 5) | k);
   endfunction

   task automatic put(input logic [7:0] b, input int gapmax);
      repeat ($urandom_range(gapmax, 0)) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic clear_stats();
      got_q.delete();
      fd_cnt = 0;
      fd_with_we = 0;
      wreq_cnt = 0;
   endtask

   task automatic send_file(input int gapmax, input int bpp, input int abort_at, input bit mid_start);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 54; i++) put(hdr_byte(i, bpp), gapmax);
      if (gapmax == 0 && bpp == 24) chk("state_after_hdr", 32'(state_code), 32'd2);
      for (int p = 0; p < W * H; p++) begin
         if (p == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            chk("abort_write_en", 32'(write_en), 32'd0);
            chk("abort_write_data", 32'(write_data), 32'd0);
            chk("abort_write_req", 32'(write_req), 32'd0);
            chk("abort_frame_done", 32'(frame_done), 32'd0);
            chk("abort_state", 32'(state_code), 32'd0);
            rst = 1'b0;
         end
         if (mid_start && p == 3) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         put(8'(8 * p), gapmax);
         put(8'(4 * p), gapmax);
         put(8'(8 * (p + 1)), gapmax);
         if (p % W == W - 1) put(8'hAA, gapmax);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int n);
      chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
      for (int k = 0; k < n && k < got_q.size(); k++)
         chk($sformatf("%s_px%0d", tag, k), 32'(got_q[k]), 32'(exp_px(k)));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_write_req", 32'(write_req), 32'd0);
      chk("rst_write_en", 32'(write_en), 32'd0);
      chk("rst_write_data", 32'(write_data), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_state", 32'(state_code), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Bytes in IDLE are dropped
      clear_stats();
      for (int i = 0; i < 6; i++) put(8'hF8, 0);
      chk("idle_no_write", 32'(got_q.size()), 32'd0);
      chk("idle_state", 32'(state_code), 32'd0);

      // Full-rate frame
      clear_stats();
      send_file(0, 24, -1, 1'b0);
      check_frame("full", W * H);
      chk("full_frame_done", 32'(fd_cnt), 32'd1);
      chk("full_fd_with_last_we", 32'(fd_with_we), 32'd1);
      chk("full_write_req_cycles", 32'(wreq_cnt), 32'd54);
      chk("full_state_done", 32'(state_code), 32'd3);
      chk("full_error", 32'(error), 32'd0);

      // Bytes in DONE are dropped
      clear_stats();
      for (int i = 0; i < 6; i++) put(8'h55, 0);
      chk("done_no_write", 32'(got_q.size()), 32'd0);
      chk("done_state", 32'(state_code), 32'd3);

      // Throttled stream with a start pulse that must be ignored mid-frame
      clear_stats();
      send_file(9, 24, -1, 1'b1);
      check_frame("gaps", W * H);
      chk("gaps_frame_done", 32'(fd_cnt), 32'd1);
      chk("gaps_write_req_low", 32'(write_req), 32'd0);

      // Reset after 4 pixels, then a complete new frame
      clear_stats();
      send_file(0, 24, 4, 1'b0);
      check_frame("abort", 4);
      chk("abort_no_frame_done", 32'(fd_cnt), 32'd0);
      clear_stats();
      send_file(0, 24, -1, 1'b0);
      check_frame("after_abort", W * H);
      chk("after_abort_frame_done", 32'(fd_cnt), 32'd1);

`ifdef BMP_HEADER_PARSE_EN
      clear_stats();
      send_file(0, 32, -1, 1'b0);
      chk("bpp32_error", 32'(error), 32'd1);
      chk("bpp32_state", 32'(state_code), 32'd3);
      chk("bpp32_no_write", 32'(got_q.size()), 32'd0);
      clear_stats();
      send_file(0, 24, -1, 1'b0);
      check_frame("recover", W * H);
      chk("recover_error", 32'(error), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
